// File: rtl/sid_bus_ctrl.sv
// sid_bus_ctrl: sequences host register writes onto the SID bus.
//
// Host writes are buffered in a small FIFO and each one is issued as a
// two-phase bus cycle timed to phi2 (sid_clk). The block also drives
// SID RES: a timed reset pulse runs after system reset or on request,
// and any pending writes are flushed.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   sid_clk         phi2 from the clock divider (same clk domain)
//   wr_req/addr/data host write strobe, register address and data
//   wr_ready        FIFO can accept a write this cycle
//   sid_reset_req   one-cycle request to re-run the SID reset sequence
//   ovf_clr         clears the sticky overflow flag
//   overflow        sticky: a write arrived while the FIFO was full
//   busy            FIFO non-empty, bus cycle in flight, or reset phase
//   sid_cs_n, sid_rw, sid_addr, sid_data, sid_data_oe, sid_res_n  SID bus
//
// Handshake: a write is accepted on any clk where wr_req & wr_ready and
// sid_reset_req is low. wr_req while the FIFO is full is dropped and
// sets overflow; wr_req during the reset phase is silently ignored.
module sid_bus_ctrl #(
  parameter int FIFO_AW    = 2,
  parameter int RES_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sid_clk,
  input  logic       wr_req,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  input  logic       sid_reset_req,
  input  logic       ovf_clr,
  output logic       overflow,
  output logic       busy,
  output logic       sid_cs_n,
  output logic       sid_rw,
  output logic [4:0] sid_addr,
  output logic [7:0] sid_data,
  output logic       sid_data_oe,
  output logic       sid_res_n
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [7:0] RES_LAST = 8'(RES_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RESET  = 2'd0,
    S_IDLE   = 2'd1,
    S_ACTIVE = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t state, state_nxt;

  // phi2 edge detection
  logic sid_clk_d;
  logic rise, fall;

  // FIFO storage: {addr, data}
  logic [12:0]      mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr, rd_ptr;
  logic             empty, full, push, pop;
  logic [12:0]      head;

  logic [7:0] res_cnt, res_cnt_nxt;
  logic       cs_n_nxt, rw_nxt, oe_nxt, res_n_nxt;
  logic [4:0] addr_nxt;
  logic [7:0] data_nxt;

  assign rise = sid_clk & ~sid_clk_d;
  assign fall = ~sid_clk & sid_clk_d;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                 (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign head  = mem[rd_ptr[FIFO_AW-1:0]];

  assign wr_ready = ~full & (state != S_RESET);
  assign busy     = ~empty | (state != S_IDLE);

  // A reset request discards a same-cycle write and blocks the pop.
  assign push = wr_req & wr_ready & ~sid_reset_req;
  assign pop  = (state == S_IDLE) & fall & ~empty & ~sid_reset_req;

  always_ff @(posedge clk) begin
    sid_clk_d <= sid_clk;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[FIFO_AW-1:0]] <= {wr_addr, wr_data};
  end

  // State register plus all registered bus outputs, FIFO pointers, flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_RESET;
      res_cnt     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      overflow    <= 1'b0;
      sid_cs_n    <= 1'b1;
      sid_rw      <= 1'b1;
      sid_addr    <= '0;
      sid_data    <= '0;
      sid_data_oe <= 1'b0;
      sid_res_n   <= 1'b0;
    end else begin
      state       <= state_nxt;
      res_cnt     <= res_cnt_nxt;
      sid_cs_n    <= cs_n_nxt;
      sid_rw      <= rw_nxt;
      sid_addr    <= addr_nxt;
      sid_data    <= data_nxt;
      sid_data_oe <= oe_nxt;
      sid_res_n   <= res_n_nxt;
      if (sid_reset_req) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      // Setting wins over clearing so a drop is never lost.
      if (wr_req & full)  overflow <= 1'b1;
      else if (ovf_clr)   overflow <= 1'b0;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_RESET:  if (rise && res_cnt == RES_LAST) state_nxt = S_IDLE;
      S_IDLE:   if (pop) state_nxt = S_ACTIVE;
      S_ACTIVE: if (fall) state_nxt = S_HOLD;
      S_HOLD:   state_nxt = S_IDLE;
      default:  state_nxt = S_RESET;
    endcase
    if (sid_reset_req) state_nxt = S_RESET;
  end

  // Output logic: next values of the registered bus outputs
  always_comb begin
    cs_n_nxt    = sid_cs_n;
    rw_nxt      = sid_rw;
    addr_nxt    = sid_addr;
    data_nxt    = sid_data;
    oe_nxt      = sid_data_oe;
    res_n_nxt   = sid_res_n;
    res_cnt_nxt = res_cnt;
    case (state)
      S_RESET: begin
        res_n_nxt = 1'b0;
        cs_n_nxt  = 1'b1;
        if (rise) begin
          if (res_cnt == RES_LAST) res_n_nxt = 1'b1;
          else                     res_cnt_nxt = res_cnt + 8'd1;
        end
      end
      S_IDLE: begin
        if (pop) begin
          addr_nxt = head[12:8];
          data_nxt = head[7:0];
          cs_n_nxt = 1'b0;
          rw_nxt   = 1'b0;
          oe_nxt   = 1'b1;
        end
      end
      S_ACTIVE: begin
        // Release CS on the second fall; data stays driven one more clk.
        if (fall) begin
          cs_n_nxt = 1'b1;
          rw_nxt   = 1'b1;
        end
      end
      S_HOLD: oe_nxt = 1'b0;
      default: ;
    endcase
    if (sid_reset_req) begin
      cs_n_nxt    = 1'b1;
      rw_nxt      = 1'b1;
      oe_nxt      = 1'b0;
      res_n_nxt   = 1'b0;
      res_cnt_nxt = '0;
    end
  end

endmodule

// File: doc/sid_bus_ctrl.md
Name: sid_bus_ctrl

Overview:
- Sequences all CPU-side register writes onto the SID bus, timed to the divided SID phi2 clock from the clock divider (same clk domain).
- Buffers host write requests in a small FIFO and issues at most one SID write per two phi2 cycles.
- Owns the SID RES line: runs a timed reset pulse after system reset or on host request, flushing pending writes.

Parameters:
- FIFO_AW, 2, log2 of FIFO depth (depth = 2**FIFO_AW).
- RES_CYCLES, 16, number of sid_clk rising edges sid_res_n is held low (range 1..255).

Ports:
- clk  in  1  system clock, same clock as the clock divider.
- rst  in  1  synchronous, active-high reset.
- sid_clk  in  1  phi2 from the clock divider, registered in the clk domain.
- wr_req  in  1  one-cycle write strobe from the host.
- wr_addr  in  5  SID register address.
- wr_data  in  8  SID register data.
- wr_ready  out  1  FIFO can accept a write: !full and not in reset phase.
- sid_reset_req  in  1  one-cycle request to re-run the reset sequence.
- ovf_clr  in  1  clears the overflow flag.
- overflow  out  1  sticky: a wr_req was dropped.
- busy  out  1  FIFO non-empty, state != IDLE, or reset phase active.
- sid_cs_n  out  1  SID chip select, active low.
- sid_rw  out  1  SID R/W; held at 0 (write) only while a write is in progress.
- sid_addr  out  5  SID address bus.
- sid_data  out  8  SID data bus.
- sid_data_oe  out  1  data bus output enable.
- sid_res_n  out  1  SID reset, active low.

Behaviour:
- Edge detect: sid_clk_d registered each clk. rise = sid_clk & !sid_clk_d; fall = !sid_clk & sid_clk_d.
- rst values:
  - outputs: sid_cs_n=1, sid_rw=1, sid_addr=0, sid_data=0, sid_data_oe=0, sid_res_n=0, overflow=0, wr_ready=0, busy=1.
  - internal: FIFO empty, state=RESET, reset counter=0.
- RESET state:
  - Drive sid_res_n=0 and sid_cs_n=1; count rise events.
  - When the count reaches RES_CYCLES: sid_res_n<=1, go to IDLE on that cycle.
  - wr_req is ignored; it is not counted as overflow.
- IDLE:
  - On fall with FIFO non-empty: pop head; load sid_addr and sid_data; sid_cs_n<=0, sid_rw<=0, sid_data_oe<=1; go to ACTIVE.
  - Outputs change one clk after the fall is detected.
- ACTIVE:
  - Hold all bus outputs stable through the phi2-high half.
  - On the next fall: sid_cs_n<=1, sid_rw<=1; addr, data and oe stay unchanged; go to HOLD.
- HOLD:
  - Exactly 1 clk; gives data hold after CS release.
  - Then sid_data_oe<=0 and go to IDLE.
  - sid_addr and sid_data keep their last values.
- Throughput: the earliest next write starts on the fall after HOLD, so back-to-back writes are spaced 2 phi2 periods.
- FIFO:
  - A push on wr_req & wr_ready is visible to the IDLE pop on the following clk.
  - wr_req while full is dropped and sets overflow, even if a pop occurs in the same cycle.
  - A pop and a push in the same cycle (not full) are both honoured.
  - Pointers are FIFO_AW+1 bits and wrap naturally.
- overflow: set has priority over ovf_clr in the same cycle; cleared only by ovf_clr or rst.
- sid_reset_req, in any state:
  - Next clk: abort the current write (sid_cs_n=1, sid_rw=1, sid_data_oe=0), flush the FIFO, zero the counter, enter RESET.
  - A wr_req in the same cycle is discarded.
  - A sid_reset_req during RESET restarts the count.
- wr_ready is combinational: !full & (state != RESET).

Test Plan:
- Power-up (SYS_CLK=20 MHz, sid_clk=1 MHz, RES_CYCLES=16): assert rst 3 clk → sid_res_n=0 for 16 sid_clk rises (~320 clk), then sid_res_n=1 and wr_ready=1.
- Single write addr=0x18, data=0x0F → cs_n low from 1 clk after the next fall for exactly 20 clk; addr/data stable throughout; oe drops 1 clk after cs_n rises.
- Burst of 4 writes (0x00..0x03, data 0xA0..0xA3) in 4 consecutive clk → all accepted, issued in order, cs_n low windows 40 clk apart.
- Fifth write with FIFO full (depth 4) → wr_ready=0, write dropped, overflow=1; ovf_clr → overflow=0; the four buffered writes still emitted correctly.
- sid_reset_req while cs_n=0 with 2 writes queued → cs_n=1 and oe=0 next clk, FIFO empty, sid_res_n=0 for 16 rises, no queued write ever appears.
- wr_req during RESET → ignored, overflow stays 0.
